lcd_char_writer: RTL and testbench
==================================

Name: lcd_char_writer

Overview:
- Downstream consumer of the message-generator stages ("Success" and similar). It accepts one ASCII character per valid/ready handshake and drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus.
- It owns the power-up init sequence, E-strobe timing, and cursor/line wrap, so the message generators only produce characters.

Parameters:
- POWERUP_CYC, 750000: idle cycles after reset before the first init command (15 ms at 50 MHz).
- E_PULSE_CYC, 25: cycles lcd_e is held high per transaction.
- CMD_WAIT_CYC, 2500: post-strobe wait for normal commands and data writes.
- CLEAR_WAIT_CYC, 100000: post-strobe wait after a 0x01 clear command.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- char_data, input, 8: ASCII character to write.
- char_valid, input, 1: char_data is valid.
- char_ready, output, 1: block can accept a character or a clear this cycle.
- clear_req, input, 1: request display clear and cursor home.
- init_done, output, 1: init sequence has completed.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: constant 0 (write only).
- lcd_e, output, 1: enable strobe.
- lcd_db, output, 8: LCD data bus.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - While reset is high, all outputs are 0, pos = 0, and state = PWRUP.
  - Reset asserted mid-transaction aborts it. lcd_e drops to 0 the next edge, and the full init sequence re-runs.
- States: PWRUP, SETUP, STROBE, HOLD, WAIT, IDLE.
- PWRUP: count POWERUP_CYC cycles, counting from the first cycle with reset low, then start the init list.
- Init list, in order: 0x38 (function set), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment). All have rs = 0.
- One bus transaction is 1 + E_PULSE_CYC + 1 + wait cycles:
  - SETUP, 1 cycle: lcd_rs and lcd_db driven, lcd_e = 0.
  - STROBE, E_PULSE_CYC cycles: lcd_e = 1.
  - HOLD, 1 cycle: lcd_e = 0, lcd_db unchanged.
  - WAIT: CLEAR_WAIT_CYC cycles if the byte was a 0x01 command, otherwise CMD_WAIT_CYC.
- lcd_rs and lcd_db keep their last value outside SETUP..HOLD. They change only on entry to SETUP.
- init_done rises on entry to IDLE after the last init command and stays high until reset.
- char_ready is 1 only in IDLE.
- Handshake:
  - Accept when char_valid && char_ready, or clear_req && char_ready.
  - char_ready drops the cycle after acceptance. char_data is captured on the accept edge, so upstream may change it immediately.
- clear_req and char_valid in the same IDLE cycle: the clear wins. The character is not accepted, and char_valid must remain asserted to be taken later.
- Clear: issue command 0x01, wait CLEAR_WAIT_CYC, set pos = 0, return to IDLE.
- Character write and wrap:
  - Issue a data transaction (rs = 1, db = char), then pos = pos + 1. pos is 5 bits, range 0..31.
  - pos becomes 16: immediately issue command 0xC0 (line 2 home) before returning to IDLE.
  - pos becomes 32: issue command 0x80, set pos = 0.
  - char_ready stays low throughout any auto-issued command.
- Inputs arriving in non-IDLE states are ignored, never queued.
- Counters are sized with $clog2 of the largest parameter plus 1. No counter wraps within any legal parameter range.

Decomposition:
- Shared package lcd_pkg:
  - Command constants: LCD_FUNC_SET = 8'h38, LCD_DISP_ON = 8'h0C, LCD_CLEAR = 8'h01, LCD_ENTRY = 8'h06, LCD_LINE1 = 8'h80, LCD_LINE2 = 8'hC0.
  - LCD_COLS = 16 and the state enum.
- One sub-module, lcd_bus_cycle:
  - Inputs: start, rs, byte, long_wait.
  - Outputs: lcd_rs, lcd_e, lcd_db, done.
  - Owns SETUP/STROBE/HOLD/WAIT timing.
- The top level holds the sequencer, handshake and pos counter.

Test Plan:
All scenarios use POWERUP_CYC = 20, E_PULSE_CYC = 4, CMD_WAIT_CYC = 10, CLEAR_WAIT_CYC = 30.
- Init: release reset at cycle 0.
  - Required: bytes 0x38, 0x0C, 0x01, 0x06 are strobed with rs = 0. The first lcd_e rise is at cycle 21.
  - Required: each lcd_e high pulse is exactly 4 cycles. init_done and char_ready rise at cycle 104.
- Single char: after init, present 'S' (0x53) with char_valid for 1 cycle.
  - Required: rs = 1, db = 0x53, one 4-cycle lcd_e pulse. char_ready returns 16 cycles after acceptance.
- Wrap: stream 33 characters 'A'..'a' (0x41 + n).
  - Required: 0xC0 is issued after the 16th character and 0x80 after the 32nd, both with rs = 0. The 33rd character is written after 0x80.
- Simultaneous: clear_req and char_valid are both high in IDLE with pos = 5.
  - Required: 0x01 is issued first with a 30-cycle wait, then pos = 0, then the character is written.
- Reset mid-op: assert reset during STROBE of a data write.
  - Required: lcd_e = 0 and char_ready = 0 on the next edge, and init_done = 0. After release, the full init sequence replays with identical timing.
- Backpressure: hold char_valid high with changing char_data while the block is busy.
  - Required: only the values present at accept edges appear on lcd_db. No bytes are dropped or duplicated.

Source files
------------

// File: rtl/lcd_char_writer_pkg.sv
// Shared command bytes, state encodings and small helpers for the HD44780 character writer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int LCD_COLS = 16;
    localparam int INIT_LEN = 4;

    // Bus-level phases of one write transaction.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT
    } bus_state_t;

    // Sequencer phases: power-up delay, init list, idle, and the three kinds of busy.
    typedef enum logic [2:0] {
        SEQ_PWRUP,
        SEQ_INIT,
        SEQ_IDLE,
        SEQ_CLEAR,
        SEQ_CHAR,
        SEQ_WRAP
    } seq_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_CLEAR;
            default: cmd = LCD_ENTRY;
        endcase
        return cmd;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// Character handshake between a message generator (master) and the LCD writer (slave).
interface lcd_char_writer_if;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       clear_req;

    modport master (
        output char_data,
        output char_valid,
        output clear_req,
        input  char_ready
    );

    modport slave (
        input  char_data,
        input  char_valid,
        input  clear_req,
        output char_ready
    );
endinterface

// File: rtl/lcd_char_writer_bus_cycle.sv
// One HD44780 write: SETUP drives rs/db, STROBE holds E high, HOLD keeps db, then the settle WAIT.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] bus_byte,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       done
);

    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bus_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             long_reg;
    logic [CNT_W-1:0] wait_last;
    logic             can_start;

    assign wait_last = long_reg ? CLR_LAST : CMD_LAST;
    // done marks the last WAIT cycle so the next transaction can start with no gap.
    assign done      = (state_reg == ST_WAIT) && (cnt_reg == wait_last);
    assign can_start = (state_reg == ST_IDLE) || done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            long_reg  <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_db    <= 8'h00;
        end else if (start && can_start) begin
            state_reg <= ST_SETUP;
            cnt_reg   <= '0;
            long_reg  <= long_wait;
            lcd_rs    <= rs;
            lcd_db    <= bus_byte;
        end else begin
            case (state_reg)
                ST_SETUP: begin
                    state_reg <= ST_STROBE;
                    lcd_e     <= 1'b1;
                    cnt_reg   <= '0;
                end
                ST_STROBE: begin
                    if (cnt_reg == E_LAST) begin
                        state_reg <= ST_HOLD;
                        lcd_e     <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    state_reg <= ST_WAIT;
                    cnt_reg   <= '0;
                end
                ST_WAIT: begin
                    if (done) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-up init, per-character handshake, clear, and line wrap.
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic               clk,
    input  logic               reset,
    lcd_char_writer_if.slave   up,
    output logic               init_done,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_e,
    output logic [7:0]         lcd_db
);

    localparam int CNT_W = $clog2(max_int(max_int(POWERUP_CYC, E_PULSE_CYC),
                                          max_int(CMD_WAIT_CYC, CLEAR_WAIT_CYC))) + 1;
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t       seq_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       init_idx_reg;
    logic [4:0]       pos_reg;
    logic             init_done_reg;
    logic             char_ready_reg;

    logic             bus_start;
    logic             bus_rs;
    logic [7:0]       bus_byte;
    logic             bus_long;
    logic             bus_done;
    logic [4:0]       pos_inc;

    assign lcd_rw        = 1'b0;
    assign init_done     = init_done_reg;
    assign up.char_ready = char_ready_reg;
    assign bus_long      = !bus_rs && (bus_byte == LCD_CLEAR);

    // The next bus transaction is launched combinationally so it lands in the cycle right after a decision.
    always_comb begin
        bus_start = 1'b0;
        bus_rs    = 1'b0;
        bus_byte  = LCD_FUNC_SET;
        pos_inc   = pos_reg + 5'd1;
        case (seq_reg)
            SEQ_PWRUP: begin
                if (cnt_reg == PWR_LAST) begin
                    bus_start = 1'b1;
                    bus_byte  = init_cmd(2'd0);
                end
            end
            SEQ_INIT: begin
                if (bus_done && (init_idx_reg != 3'(INIT_LEN))) begin
                    bus_start = 1'b1;
                    bus_byte  = init_cmd(init_idx_reg[1:0]);
                end
            end
            SEQ_IDLE: begin
                // A clear outranks a pending character; the character stays on the bus for later.
                if (up.clear_req) begin
                    bus_start = 1'b1;
                    bus_byte  = LCD_CLEAR;
                end else if (up.char_valid) begin
                    bus_start = 1'b1;
                    bus_rs    = 1'b1;
                    bus_byte  = up.char_data;
                end
            end
            SEQ_CHAR: begin
                if (bus_done && (pos_inc == 5'(LCD_COLS))) begin
                    bus_start = 1'b1;
                    bus_byte  = LCD_LINE2;
                end else if (bus_done && (pos_inc == 5'd0)) begin
                    bus_start = 1'b1;
                    bus_byte  = LCD_LINE1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_reg        <= SEQ_PWRUP;
            cnt_reg        <= '0;
            init_idx_reg   <= 3'd0;
            pos_reg        <= 5'd0;
            init_done_reg  <= 1'b0;
            char_ready_reg <= 1'b0;
        end else begin
            case (seq_reg)
                SEQ_PWRUP: begin
                    if (cnt_reg == PWR_LAST) begin
                        seq_reg      <= SEQ_INIT;
                        init_idx_reg <= 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                SEQ_INIT: begin
                    if (bus_done) begin
                        if (init_idx_reg == 3'(INIT_LEN)) begin
                            seq_reg        <= SEQ_IDLE;
                            init_done_reg  <= 1'b1;
                            char_ready_reg <= 1'b1;
                        end else begin
                            init_idx_reg <= init_idx_reg + 3'd1;
                        end
                    end
                end
                SEQ_IDLE: begin
                    if (bus_start) begin
                        seq_reg        <= up.clear_req ? SEQ_CLEAR : SEQ_CHAR;
                        char_ready_reg <= 1'b0;
                    end
                end
                SEQ_CLEAR: begin
                    if (bus_done) begin
                        pos_reg        <= 5'd0;
                        seq_reg        <= SEQ_IDLE;
                        char_ready_reg <= 1'b1;
                    end
                end
                SEQ_CHAR: begin
                    if (bus_done) begin
                        // pos wraps 31 -> 0 naturally, which is exactly the line-1 home case.
                        pos_reg <= pos_inc;
                        if (bus_start) begin
                            seq_reg <= SEQ_WRAP;
                        end else begin
                            seq_reg        <= SEQ_IDLE;
                            char_ready_reg <= 1'b1;
                        end
                    end
                end
                SEQ_WRAP: begin
                    if (bus_done) begin
                        seq_reg        <= SEQ_IDLE;
                        char_ready_reg <= 1'b1;
                    end
                end
                default: seq_reg <= SEQ_PWRUP;
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .CNT_W          (CNT_W)
    ) u_bus (
        .clk       (clk),
        .reset     (reset),
        .start     (bus_start),
        .rs        (bus_rs),
        .bus_byte  (bus_byte),
        .long_wait (bus_long),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db),
        .done      (bus_done)
    );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: init timing, single write, wrap, clear priority, reset abort, backpressure.
module tb_lcd_char_writer;
    import lcd_pkg::*;

    localparam int LIMIT = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    lcd_char_writer_if up_if ();

    lcd_char_writer #(
        .POWERUP_CYC    (20),
        .E_PULSE_CYC    (4),
        .CMD_WAIT_CYC   (10),
        .CLEAR_WAIT_CYC (30)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (up_if),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         rise;
        int         width;
        logic       stable;
    } txn_t;

    txn_t       q[$];
    txn_t       exp_q[$];
    txn_t       cur;
    logic       e_prev = 1'b0;
    logic [4:0] model_pos = 5'd0;

    // Bus monitor: one record per E pulse, with rise cycle, width and rs/db stability.
    always @(negedge clk) begin
        if (lcd_e === 1'b1 && e_prev === 1'b0) begin
            cur.rs     = lcd_rs;
            cur.db     = lcd_db;
            cur.rise   = cyc - base;
            cur.width  = 0;
            cur.stable = 1'b1;
        end else if (e_prev === 1'b1) begin
            if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 1'b0;
            if (lcd_e !== 1'b1) begin
                cur.width = cyc - base - cur.rise;
                q.push_back(cur);
                $display("[TB] txn rs=%0d db=0x%02h rise=%0d width=%0d", cur.rs, cur.db, cur.rise, cur.width);
            end
        end
        e_prev = lcd_e;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic txn_t mk(input logic rs, input logic [7:0] db);
        txn_t t;
        t.rs = rs; t.db = db; t.rise = 0; t.width = 4; t.stable = 1'b1;
        return t;
    endfunction

    task automatic model_char(input logic [7:0] c);
        exp_q.push_back(mk(1'b1, c));
        model_pos = model_pos + 5'd1;
        if (model_pos == 5'd16) exp_q.push_back(mk(1'b0, 8'hC0));
        else if (model_pos == 5'd0) exp_q.push_back(mk(1'b0, 8'h80));
    endtask

    task automatic model_clear();
        exp_q.push_back(mk(1'b0, 8'h01));
        model_pos = 5'd0;
    endtask

    // Returns at a falling edge with char_ready high; t is that cycle index.
    task automatic wait_idle(input string tag, output int t);
        int n = 0;
        @(negedge clk);
        while (up_if.char_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= LIMIT), 32'd0);
        t = cyc - base;
    endtask

    task automatic send_char(input logic [7:0] c, output int acc);
        int n = 0;
        @(negedge clk);
        up_if.char_valid = 1'b1;
        up_if.char_data  = c;
        while (up_if.char_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n >= LIMIT), 32'd0);
        @(posedge clk);
        #1;
        acc = cyc - base;
        up_if.char_valid = 1'b0;
        up_if.char_data  = 8'h00;
        model_char(c);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d_rs", tag, i), 32'(q[i].rs), 32'(exp_q[i].rs));
            check($sformatf("%s_%0d_db", tag, i), 32'(q[i].db), 32'(exp_q[i].db));
            check($sformatf("%s_%0d_width", tag, i), 32'(q[i].width), 32'd4);
            check($sformatf("%s_%0d_stable", tag, i), 32'(q[i].stable), 32'd1);
        end
        q.delete();
        exp_q.delete();
    endtask

    task automatic check_init(input string tag);
        logic [7:0] idb [4];
        int         irise [4];
        int         n = 0;
        idb   = '{8'h38, 8'h0C, 8'h01, 8'h06};
        irise = '{21, 37, 53, 89};
        while (init_done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= LIMIT), 32'd0);
        check({tag, "_done_cycle"}, 32'(cyc - base), 32'd104);
        check({tag, "_ready"}, 32'(up_if.char_ready), 32'd1);
        check({tag, "_count"}, 32'(q.size()), 32'd4);
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            check($sformatf("%s_%0d_rs", tag, i), 32'(q[i].rs), 32'd0);
            check($sformatf("%s_%0d_db", tag, i), 32'(q[i].db), 32'(idb[i]));
            check($sformatf("%s_%0d_rise", tag, i), 32'(q[i].rise), 32'(irise[i]));
            check($sformatf("%s_%0d_width", tag, i), 32'(q[i].width), 32'd4);
        end
        q.delete();
    endtask

    initial begin
        int acc;
        int t;
        int n;
        int accepts;
        logic [7:0] bp_val;

        up_if.char_valid = 1'b0;
        up_if.char_data  = 8'h00;
        up_if.clear_req  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_db", 32'(lcd_db), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(up_if.char_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;

        // Init sequence timing
        check_init("init");

        // Single character
        send_char(8'h53, acc);
        check("single_ready_drop", 32'(up_if.char_ready), 32'd0);
        wait_idle("single_idle", t);
        check("single_ready_latency", 32'(t - acc), 32'd16);
        compare_all("single");

        // Plain clear: 30-cycle wait, pos back to 0
        wait_idle("clr_idle", t);
        up_if.clear_req = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc - base;
        up_if.clear_req = 1'b0;
        model_clear();
        wait_idle("clr_done", t);
        check("clear_ready_latency", 32'(t - acc), 32'd36);
        compare_all("clear");

        // Wrap: 33 characters 'A'..'a' from pos 0
        for (int i = 0; i < 33; i++) send_char(8'(8'h41 + i), acc);
        wait_idle("wrap_idle", t);
        check("wrap_total", 32'(q.size()), 32'd35);
        if (q.size() == 35) begin
            check("wrap_c0_db", 32'(q[16].db), 32'hC0);
            check("wrap_c0_rs", 32'(q[16].rs), 32'd0);
            check("wrap_80_db", 32'(q[33].db), 32'h80);
            check("wrap_80_rs", 32'(q[33].rs), 32'd0);
            check("wrap_last_db", 32'(q[34].db), 32'h61);
            check("wrap_last_rs", 32'(q[34].rs), 32'd1);
        end
        compare_all("wrap");

        // Advance pos to 5
        for (int i = 0; i < 4; i++) send_char(8'(8'h62 + i), acc);
        wait_idle("pos5_idle", t);
        compare_all("pos5");

        // Clear and character together: clear first, character held and taken afterwards
        wait_idle("sim_idle", t);
        up_if.clear_req  = 1'b1;
        up_if.char_valid = 1'b1;
        up_if.char_data  = 8'h5A;
        @(posedge clk);
        #1;
        acc = cyc - base;
        up_if.clear_req = 1'b0;
        model_clear();
        check("sim_ready_drop", 32'(up_if.char_ready), 32'd0);
        wait_idle("sim_clr", t);
        check("sim_clear_latency", 32'(t - acc), 32'd36);
        @(posedge clk);
        #1;
        up_if.char_valid = 1'b0;
        model_char(8'h5A);
        for (int i = 0; i < 15; i++) send_char(8'(8'h30 + i), acc);
        wait_idle("sim_done", t);
        check("sim_total", 32'(q.size()), 32'd18);
        if (q.size() == 18) begin
            check("sim_first_db", 32'(q[0].db), 32'h01);
            check("sim_second_db", 32'(q[1].db), 32'h5A);
            check("sim_second_rs", 32'(q[1].rs), 32'd1);
            check("sim_gap", 32'(q[1].rise - q[0].rise), 32'd37);
            check("sim_line2_db", 32'(q[17].db), 32'hC0);
        end
        compare_all("sim");

        // Backpressure: valid held, data changing every cycle
        wait_idle("bp_idle", t);
        bp_val  = 8'h70;
        accepts = 0;
        n       = 0;
        up_if.char_valid = 1'b1;
        while (accepts < 3 && n < LIMIT) begin
            up_if.char_data = bp_val;
            bp_val = bp_val + 8'd1;
            if (up_if.char_ready === 1'b1) begin
                model_char(up_if.char_data);
                accepts++;
            end
            @(negedge clk);
            n++;
        end
        up_if.char_valid = 1'b0;
        check("bp_timeout", 32'(n >= LIMIT), 32'd0);
        wait_idle("bp_done", t);
        compare_all("bp");

        // Reset during the E strobe of a data write
        wait_idle("abort_idle", t);
        send_char(8'h52, acc);
        n = 0;
        while (lcd_e !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("abort_timeout", 32'(n >= LIMIT), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_e", 32'(lcd_e), 32'd0);
        check("abort_ready", 32'(up_if.char_ready), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        check("abort_db", 32'(lcd_db), 32'd0);
        repeat (3) @(posedge clk);
        q.delete();
        exp_q.delete();
        model_pos = 5'd0;
        #1;
        reset = 1'b0;
        base  = cyc;
        check_init("reinit");

        // A write after re-init lands at pos 0
        send_char(8'h4F, acc);
        wait_idle("post_idle", t);
        compare_all("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
